// File: rtl/vga_ctrl_if.sv
// Pixel request / display bus between the VGA timing controller (master)
// and the picture generator plus display pins (slave).
interface vga_ctrl_if;
  logic [15:0] pix_data;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        pix_data_req;
  logic        hsync;
  logic        vsync;
  logic        rgb_valid;
  logic [15:0] rgb;
  logic        frame_start;
  logic [7:0]  frame_cnt;

  modport master (
    input  pix_data,
    output pix_x, pix_y, pix_data_req, hsync, vsync,
           rgb_valid, rgb, frame_start, frame_cnt
  );

  modport slave (
    output pix_data,
    input  pix_x, pix_y, pix_data_req, hsync, vsync,
           rgb_valid, rgb, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_ctrl.sv
// 640x480@60 VGA timing controller: scan counters, sync pulses, pixel request
// one clock ahead of display, and a one-stage pixel register feeding rgb.
module vga_ctrl #(
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 40,
  parameter int   H_LEFT      = 8,
  parameter int   H_VALID     = 640,
  parameter int   H_RIGHT     = 8,
  parameter int   H_FRONT     = 8,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 25,
  parameter int   V_TOP       = 8,
  parameter int   V_VALID     = 480,
  parameter int   V_BOTTOM    = 8,
  parameter int   V_FRONT     = 2,
  parameter logic SYNC_ACTIVE = 1'b1
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  vga_ctrl_if.master  vga
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
  localparam int HA_I    = H_SYNC + H_BACK + H_LEFT;
  localparam int VA_I    = V_SYNC + V_BACK + V_TOP;

  localparam logic [9:0] HT_M1 = 10'(H_TOTAL - 1);
  localparam logic [9:0] VT_M1 = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS    = 10'(H_SYNC);
  localparam logic [9:0] VS    = 10'(V_SYNC);
  localparam logic [9:0] HA    = 10'(HA_I);
  localparam logic [9:0] HA_M1 = 10'(HA_I - 1);
  localparam logic [9:0] HE    = 10'(HA_I + H_VALID);
  localparam logic [9:0] HE_M1 = 10'(HA_I + H_VALID - 1);
  localparam logic [9:0] VA    = 10'(VA_I);
  localparam logic [9:0] VE    = 10'(VA_I + V_VALID);

  logic [9:0]  cnt_h;
  logic [9:0]  cnt_v;
  logic [15:0] pix_reg;
  logic [7:0]  frame_cnt_q;
  logic        h_end;
  logic        v_end;
  logic        line_act;
  logic        req;
  logic        act;

  assign h_end    = (cnt_h == HT_M1);
  assign v_end    = (cnt_v == VT_M1);
  assign line_act = (cnt_v >= VA) && (cnt_v < VE);

  // Decodes are gated with reset so every output is at its idle value while
  // reset is held, even though the cleared counters point at the sync region.
  assign req = sys_rst_n && line_act && (cnt_h >= HA_M1) && (cnt_h < HE_M1);
  assign act = sys_rst_n && line_act && (cnt_h >= HA) && (cnt_h < HE);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h       <= '0;
      cnt_v       <= '0;
      frame_cnt_q <= '0;
    end else begin
      cnt_h <= h_end ? 10'd0 : cnt_h + 10'd1;
      if (h_end)
        cnt_v <= v_end ? 10'd0 : cnt_v + 10'd1;
      if (h_end && v_end)
        frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  // Pixel returned for the request of this cycle is shown next cycle.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      pix_reg <= '0;
    else if (req)
      pix_reg <= vga.pix_data;
  end

  assign vga.hsync        = (sys_rst_n && (cnt_h < HS)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vga.vsync        = (sys_rst_n && (cnt_v < VS)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vga.pix_data_req = req;
  assign vga.pix_x        = req ? (cnt_h - HA_M1) : 10'h3FF;
  assign vga.pix_y        = req ? (cnt_v - VA) : 10'h3FF;
  assign vga.rgb_valid    = act;
  assign vga.rgb          = act ? pix_reg : 16'h0000;
  assign vga.frame_start  = sys_rst_n && (cnt_h == 10'd0) && (cnt_v == 10'd0);
  assign vga.frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: a full-size instance for line/pixel timing and a shrunken
// instance for multi-frame behaviour, both compared every cycle to a scan model.
`timescale 1ns/1ps
module tb_vga_ctrl;

  localparam int S_HSY = 3, S_HB = 2, S_HL = 1, S_HV = 10, S_HR = 1, S_HF = 3;
  localparam int S_VSY = 2, S_VB = 2, S_VT = 1, S_VV = 4, S_VBO = 1, S_VF = 2;
  localparam int S_HT = 20, S_VTOT = 12, S_FR = S_HT * S_VTOT;
  localparam int B_FR_LINE = 800;

  typedef struct packed {
    logic        hs, vs, req, val, fs;
    logic [9:0]  x, y;
    logic [15:0] rgb;
    logic [7:0]  fc;
  } outs_t;

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  logic rst_s = 1'b1;
  int   t0 = 0, t1 = 0;
  int   nchk = 0, nerr = 0;
  logic [15:0] noise_b, noise_s;
  logic [15:0] lut [S_HV*S_VV];

  vga_ctrl_if vb ();
  vga_ctrl_if vs ();

  vga_ctrl dut_b (.vga_clk(clk), .sys_rst_n(rst_b), .vga(vb));

  vga_ctrl #(
    .H_SYNC(S_HSY), .H_BACK(S_HB), .H_LEFT(S_HL), .H_VALID(S_HV), .H_RIGHT(S_HR), .H_FRONT(S_HF),
    .V_SYNC(S_VSY), .V_BACK(S_VB), .V_TOP(S_VT), .V_VALID(S_VV), .V_BOTTOM(S_VBO), .V_FRONT(S_VF),
    .SYNC_ACTIVE(1'b1)
  ) dut_s (.vga_clk(clk), .sys_rst_n(rst_s), .vga(vs));

  always #20 clk = ~clk;

  outs_t ob, os;
  assign ob = {vb.hsync, vb.vsync, vb.pix_data_req, vb.rgb_valid, vb.frame_start,
               vb.pix_x, vb.pix_y, vb.rgb, vb.frame_cnt};
  assign os = {vs.hsync, vs.vsync, vs.pix_data_req, vs.rgb_valid, vs.frame_start,
               vs.pix_x, vs.pix_y, vs.rgb, vs.frame_cnt};

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
      if (nerr >= 200) begin
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
      end
    end
  endtask

  function automatic logic [15:0] pix_fn(int inst, int x, int y);
    logic [9:0] xx, yy;
    xx = 10'(x);
    yy = 10'(y);
    if (inst == 0) return {xx[4:0], yy[5:0], xx[4:0]};
    return lut[(y * S_HV + x) % (S_HV * S_VV)];
  endfunction

  function automatic outs_t rst_outs();
    outs_t o;
    o   = '0;
    o.x = 10'h3FF;
    o.y = 10'h3FF;
    return o;
  endfunction

  // Position is derived purely from elapsed cycles since reset release.
  function automatic outs_t model(int inst, int t);
    int ht, vt, hsy, vsy, ha, va, hv, vv, h, v;
    outs_t o;
    if (inst == 0) begin
      ht = 800; vt = 525; hsy = 96; vsy = 2; ha = 144; va = 35; hv = 640; vv = 480;
    end else begin
      ht = S_HT; vt = S_VTOT; hsy = S_HSY; vsy = S_VSY;
      ha = S_HSY + S_HB + S_HL; va = S_VSY + S_VB + S_VT; hv = S_HV; vv = S_VV;
    end
    h     = t % ht;
    v     = (t / ht) % vt;
    o.hs  = (h < hsy);
    o.vs  = (v < vsy);
    o.req = (h >= ha - 1) && (h < ha + hv - 1) && (v >= va) && (v < va + vv);
    o.val = (h >= ha) && (h < ha + hv) && (v >= va) && (v < va + vv);
    o.fs  = (h == 0) && (v == 0);
    o.x   = o.req ? 10'(h - ha + 1) : 10'h3FF;
    o.y   = o.req ? 10'(v - va) : 10'h3FF;
    o.rgb = o.val ? pix_fn(inst, h - ha, v - va) : 16'h0000;
    o.fc  = 8'((t / (ht * vt)) % 256);
    return o;
  endfunction

  always_comb vb.pix_data = vb.pix_data_req ? pix_fn(0, int'(vb.pix_x), int'(vb.pix_y)) : noise_b;
  always_comb vs.pix_data = vs.pix_data_req ? pix_fn(1, int'(vs.pix_x), int'(vs.pix_y)) : noise_s;

  always @(posedge clk) begin
    t0 = rst_b ? t0 + 1 : 0;
    t1 = rst_s ? t1 + 1 : 0;
  end

  always @(negedge clk) begin
    chk("b_outs", 64'(ob), 64'(rst_b ? model(0, t0) : rst_outs()));
    chk("s_outs", 64'(os), 64'(rst_s ? model(1, t1) : rst_outs()));
    noise_b = 16'($urandom);
    noise_s = 16'($urandom);
  end

  task automatic wait_t(int inst, int target);
    for (int i = 0; i < 100000; i++) begin
      if ((inst == 0 ? t0 : t1) >= target) return;
      @(negedge clk);
    end
    chk("timeout", 64'(inst == 0 ? t0 : t1), 64'(target));
  endtask

  task automatic big_seq();
    int n;
    #1 rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
    n = 0;
    for (int i = 0; i < B_FR_LINE; i++) begin
      @(negedge clk);
      n += int'(vb.hsync);
    end
    chk("b_hs_per_line", 64'(n), 64'(96));
    wait_t(0, 35 * 800 + 142);
    chk("b_req_pre", 64'(vb.pix_data_req), 64'(0));
    @(negedge clk);
    chk("b_req_rise", 64'({vb.pix_data_req, vb.pix_x, vb.pix_y}), 64'({1'b1, 10'd0, 10'd0}));
    wait_t(0, 35 * 800 + 782);
    chk("b_x_last", 64'(vb.pix_x), 64'(639));
    @(negedge clk);
    chk("b_val_end", 64'({vb.rgb_valid, vb.pix_data_req}), 64'(2'b10));
    @(negedge clk);
    chk("b_val_off", 64'({vb.rgb_valid, vb.rgb}), 64'(0));
    wait_t(0, 36 * 800 + 144 + 17);
    chk("b_rgb_17_1", 64'(vb.rgb), 64'({5'd17, 6'd1, 5'd17}));
    wait_t(0, 36 * 800 + 400);
    chk("b_pre_rst_val", 64'(vb.rgb_valid), 64'(1));
    @(posedge clk);
    #7 rst_b = 1'b0;
    #1 chk("b_async_rst", 64'(ob), 64'(rst_outs()));
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1 rst_b = 1'b1;
    @(negedge clk);
    chk("b_restart", 64'({vb.frame_start, vb.hsync, vb.vsync}), 64'(3'b111));
    repeat (50) @(negedge clk);
  endtask

  task automatic small_seq();
    int nval, nvs, nfs, hr, vr;
    #1 rst_s = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_s = 1'b1;
    nval = 0; nvs = 0; nfs = 0;
    for (int i = 0; i < S_FR; i++) begin
      @(negedge clk);
      nval += int'(vs.rgb_valid);
      nvs  += int'(vs.vsync);
      nfs  += int'(vs.frame_start);
    end
    chk("s_val_per_frame", 64'(nval), 64'(S_HV * S_VV));
    chk("s_vs_per_frame", 64'(nvs), 64'(S_VSY * S_HT));
    chk("s_fs_per_frame", 64'(nfs), 64'(1));
    wait_t(1, 3 * S_FR - 1);
    chk("s_fc2", 64'(vs.frame_cnt), 64'(2));
    wait_t(1, 3 * S_FR);
    chk("s_fc3", 64'({vs.frame_start, vs.frame_cnt}), 64'({1'b1, 8'd3}));
    hr = $urandom_range(6, 15);
    vr = $urandom_range(5, 8);
    wait_t(1, 3 * S_FR + vr * S_HT + hr);
    @(posedge clk);
    #7 rst_s = 1'b0;
    #1 chk("s_async_rst", 64'(os), 64'(rst_outs()));
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1 rst_s = 1'b1;
    @(negedge clk);
    chk("s_restart", 64'({vs.frame_start, vs.hsync, vs.vsync, vs.frame_cnt}), 64'({3'b111, 8'd0}));
    wait_t(1, 256 * S_FR - 1);
    chk("s_fc255", 64'(vs.frame_cnt), 64'(255));
    wait_t(1, 256 * S_FR);
    chk("s_fc_wrap", 64'(vs.frame_cnt), 64'(0));
  endtask

  initial begin
    foreach (lut[i]) lut[i] = 16'($urandom);
    noise_b = 16'($urandom);
    noise_s = 16'($urandom);
    fork
      big_seq();
      small_seq();
    join
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", nchk, nerr);
    $fatal(1);
  end

endmodule

// File: doc/vga_ctrl.md
# vga_ctrl

VGA timing controller for 640x480@60 Hz on the 25 MHz pixel clock. It runs the horizontal and vertical scan counters and drives the sync pulses to the connector. It issues pixel coordinates to the picture generator (vga_pic_must or any module with the same pix_x/pix_y/pix_data contract), captures the returned RGB565 word, and drives it onto the display during the active window. Together with the picture generator it forms the complete LAB3 display path.

## Interface
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 40, horizontal back porch
- H_LEFT, 8, left border
- H_VALID, 640, active pixels per line
- H_RIGHT, 8, right border
- H_FRONT, 8, horizontal front porch (H_TOTAL = sum = 800)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 25, vertical back porch
- V_TOP, 8, top border
- V_VALID, 480, active lines
- V_BOTTOM, 8, bottom border
- V_FRONT, 2, vertical front porch (V_TOTAL = sum = 525)
- SYNC_ACTIVE, 1'b1, level driven on hsync/vsync during the sync pulse
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- vga_clk  in  1  pixel clock, 25 MHz; all state on rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- pix_data  in  16  RGB565 from the picture generator for the current pix_x/pix_y, valid in the same cycle (combinational source allowed)
- pix_x  out  10  requested X coordinate, 0..639, 10'h3FF when no request
- pix_y  out  10  requested Y coordinate, 0..479, 10'h3FF when no request
- pix_data_req  out  1  high while pix_x/pix_y carry a valid request
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- rgb_valid  out  1  high while rgb carries an active pixel
- rgb  out  16  RGB565 to the DAC/pins
- frame_start  out  1  one-cycle pulse at cnt_h=0, cnt_v=0
- frame_cnt  out  8  completed-frame counter

## Operation
- cnt_h (10 bit) increments every cycle and wraps H_TOTAL-1 -> 0.
- cnt_v (10 bit) increments only when cnt_h = H_TOTAL-1, and wraps V_TOTAL-1 -> 0 on the same edge that cnt_h wraps.
- Define HA = H_SYNC+H_BACK+H_LEFT (144) and VA = V_SYNC+V_BACK+V_TOP (35).
- hsync = SYNC_ACTIVE when cnt_h < H_SYNC, else ~SYNC_ACTIVE. vsync uses the same rule with cnt_v < V_SYNC.
- rgb_valid = (HA <= cnt_h < HA+H_VALID) && (VA <= cnt_v < VA+V_VALID).
- pix_data_req = (HA-1 <= cnt_h < HA+H_VALID-1) && (VA <= cnt_v < VA+V_VALID), i.e. one clock ahead of rgb_valid horizontally.
- When pix_data_req is high: pix_x = cnt_h-(HA-1), pix_y = cnt_v-VA. Otherwise both are 10'h3FF.
- pix_reg (16 bit) loads pix_data on every edge where pix_data_req is high, and holds otherwise.
- rgb = rgb_valid ? pix_reg : 16'h0000. Blanking and borders are always black.
- frame_cnt increments on the edge where cnt_h = H_TOTAL-1 and cnt_v = V_TOTAL-1, wrapping 255 -> 0.
- Reset asserted, asynchronously and at any point including mid-line or mid-frame:
  - cnt_h, cnt_v, pix_reg and frame_cnt clear immediately.
  - While reset is held, outputs are forced: hsync = vsync = ~SYNC_ACTIVE, rgb_valid = pix_data_req = frame_start = 0, rgb = 0, pix_x = pix_y = 10'h3FF.
- Reset release: the first cycle has cnt_h = cnt_v = 0, so frame_start = 1 and both syncs are active. The scan always restarts at the top of a frame.

## Timing
- Request-to-display latency is exactly 1 clock: the coordinate (x,y) is issued in cycle t, pix_data is sampled at the end of t, and rgb shows that pixel in t+1.
- Line period is 800 clocks (32 us); frame period is 800*525 = 420000 clocks (16.8 ms, ~59.5 Hz).
- hsync is active for cycles 0..95 of every line.
- vsync is active for lines 0..1, i.e. 1600 clocks, beginning at the same cycle as frame_start.
- Active video spans cnt_h 144..783 and cnt_v 35..514.
- Per active line: 640 req cycles (cnt_h 143..782) and 640 rgb_valid cycles (cnt_h 144..783).
- pix_data_req is never high on non-active lines (cnt_v < 35 or >= 515), including cnt_h = 143 on those lines.
- frame_start and the frame_cnt increment are one clock apart: the increment occurs at the edge ending the last cycle, and frame_start is high in the cycle that follows.

## Test plan
- Reset, then release and run 2 lines -> frame_start=1 in the first cycle only; hsync active exactly 96 clocks per 800; pix_x/pix_y = 3FF during line 0.
- Run to line 35 -> pix_data_req rises at cnt_h=143 with pix_x=0, pix_y=0; pix_x=639 at cnt_h=782; rgb_valid covers cnt_h 144..783.
- Drive pix_data = {pix_x[4:0], pix_y[5:0], pix_x[4:0]} from the bench -> every rgb_valid cycle shows the value for x = cnt_h-144, y = cnt_v-35; rgb = 0 in all blanking and border cycles.
- Attach vga_pic_must as the pixel source -> rgb is only ever 16'h001F or 16'hFFFF when rgb_valid is high, and 0 otherwise; 640x480 rgb_valid cycles per frame.
- Run 3 full frames -> vsync active 1600 clocks per frame, frame_start period 420000 clocks, frame_cnt = 3; force frame_cnt to 255 and run one more frame -> it wraps to 0.
- Assert sys_rst_n low asynchronously mid-line at cnt_v=200, cnt_h=400 (between clock edges) -> outputs go to their reset values with no clock edge required; on release, the scan restarts at cnt_h=0, cnt_v=0 with frame_start=1.
